key_map_decoder: RTL and testbench

KEY_MAP_DECODER -- requirements
Module: key_map_decoder

---
 rtl/key_map_decoder.sv | 163 ++++++++++++++++
 tb/tb_key_map_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/key_map_decoder.sv
// PS/2 key-to-button mapper: a downloadable table maps scan codes to held button bits,
// and every key event is resolved by sweeping the table one entry per clock.
module key_map_decoder #(
  parameter int          NUM_BTN   = 16,
  parameter int          NUM_KEYS  = 32,
  parameter logic [7:0]  TBL_INDEX = 8'd253
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [10:0]         ps2_key,
  input  logic [15:0]         dn_addr,
  input  logic [7:0]          dn_data,
  input  logic                dn_wr,
  input  logic [7:0]          dn_index,
  output logic [NUM_BTN-1:0]  btn,
  output logic                busy
);

  localparam int          IW       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [15:0] ADDR_LIM = 16'(2 * NUM_KEYS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_KEYS - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t          state_r, state_nx_s;
  logic [IW-1:0]   idx_r, idx_nx_s;
  logic [9:0]      cur_r, cur_nx_s;        // {pressed, extended, code}
  logic [9:0]      pend_r, pend_nx_s;
  logic            pend_vld_r, pend_vld_nx_s;
  logic            tog_prev_r;
  logic            evt_s;
  logic            hit_s;
  logic            ext_ok_s;
  logic [NUM_BTN-1:0] btn_nx_s;

  logic            tbl_vld_r  [NUM_KEYS];
  logic [7:0]      tbl_code_r [NUM_KEYS];
  logic [1:0]      tbl_ext_r  [NUM_KEYS];
  logic [4:0]      tbl_bidx_r [NUM_KEYS];
  logic [7:0]      stage_r;
  logic            wr_s;

  assign evt_s = (ps2_key[10] != tog_prev_r);
  assign wr_s  = dn_wr && (dn_index == TBL_INDEX) && (dn_addr < ADDR_LIM);

  // Next-state, scan index and pending-event bookkeeping
  always_comb begin
    state_nx_s    = state_r;
    idx_nx_s      = idx_r;
    cur_nx_s      = cur_r;
    pend_nx_s     = pend_r;
    pend_vld_nx_s = pend_vld_r;
    case (state_r)
      IDLE: begin
        if (pend_vld_r) begin
          state_nx_s = SCAN;
          idx_nx_s   = '0;
          cur_nx_s   = pend_r;
          if (evt_s) begin
            pend_nx_s     = ps2_key[9:0];
            pend_vld_nx_s = 1'b1;
          end else begin
            pend_vld_nx_s = 1'b0;
          end
        end else if (evt_s) begin
          state_nx_s = SCAN;
          idx_nx_s   = '0;
          cur_nx_s   = ps2_key[9:0];
        end else begin
          state_nx_s = IDLE;
        end
      end
      SCAN: begin
        if (idx_r == LAST_IDX) begin
          idx_nx_s = '0;
          // An event arriving on the final entry is newer than any pending one
          if (evt_s) begin
            state_nx_s    = SCAN;
            cur_nx_s      = ps2_key[9:0];
            pend_vld_nx_s = 1'b0;
          end else if (pend_vld_r) begin
            state_nx_s    = SCAN;
            cur_nx_s      = pend_r;
            pend_vld_nx_s = 1'b0;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          idx_nx_s = idx_r + 1'b1;
          if (evt_s) begin
            pend_nx_s     = ps2_key[9:0];
            pend_vld_nx_s = 1'b1;
          end else begin
            pend_vld_nx_s = pend_vld_r;
          end
        end
      end
      default: begin
        state_nx_s    = IDLE;
        idx_nx_s      = '0;
        pend_vld_nx_s = 1'b0;
      end
    endcase
  end

  // Match the entry under examination and derive the next button vector
  always_comb begin
    ext_ok_s = tbl_ext_r[idx_r][1] || (tbl_ext_r[idx_r][0] == cur_r[8]);
    hit_s    = (state_r == SCAN) && tbl_vld_r[idx_r] &&
               (tbl_code_r[idx_r] == cur_r[7:0]) && ext_ok_s;
    btn_nx_s = btn;
    for (int b = 0; b < NUM_BTN; b++) begin
      if (hit_s && (tbl_bidx_r[idx_r] == 5'(b))) begin
        btn_nx_s[b] = cur_r[9];
      end else begin
        btn_nx_s[b] = btn[b];
      end
    end
  end

  // Control state, event capture and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      cur_r      <= 10'd0;
      pend_r     <= 10'd0;
      pend_vld_r <= 1'b0;
      tog_prev_r <= ps2_key[10];
      btn        <= '0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      idx_r      <= idx_nx_s;
      cur_r      <= cur_nx_s;
      pend_r     <= pend_nx_s;
      pend_vld_r <= pend_vld_nx_s;
      tog_prev_r <= ps2_key[10];
      btn        <= btn_nx_s;
      busy       <= (state_nx_s == SCAN) || pend_vld_nx_s;
    end
  end

  // Key-map table: byte0 stages the code, byte1 commits the whole entry at once
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stage_r <= 8'd0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        tbl_vld_r[k] <= 1'b0;
      end
    end else if (wr_s) begin
      if (!dn_addr[0]) begin
        stage_r <= dn_data;
      end else begin
        tbl_code_r[dn_addr[IW:1]] <= stage_r;
        tbl_vld_r[dn_addr[IW:1]]  <= dn_data[7];
        tbl_ext_r[dn_addr[IW:1]]  <= dn_data[6:5];
        tbl_bidx_r[dn_addr[IW:1]] <= dn_data[4:0];
      end
    end
  end

endmodule

// File: tb/tb_key_map_decoder.sv
// Directed bench for key_map_decoder with default parameters (16 buttons, 32 entries).
module tb_key_map_decoder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [10:0] ps2_key;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [7:0]  dn_index;
  logic [15:0] btn;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int bcnt;

  key_map_decoder dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ps2_key  (ps2_key),
    .dn_addr  (dn_addr),
    .dn_data  (dn_data),
    .dn_wr    (dn_wr),
    .dn_index (dn_index),
    .btn      (btn),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [15:0] a, input logic [7:0] d, input logic [7:0] ix);
    @(negedge CLK);
    dn_addr = a; dn_data = d; dn_index = ix; dn_wr = 1'b1;
    @(negedge CLK);
    dn_wr = 1'b0;
  endtask

  task automatic wr_entry(input int k, input logic [7:0] code, input logic [7:0] b1);
    wr_byte(16'(2 * k), code, 8'd253);
    wr_byte(16'(2 * k + 1), b1, 8'd253);
  endtask

  // Toggle the event bit at the current negedge
  task automatic send_evt(input logic [7:0] code, input logic ext, input logic prs);
    ps2_key = {~ps2_key[10], prs, ext, code};
  endtask

  task automatic run(input int n, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      busy_cycles += int'(busy);
    end
  endtask

  task automatic scan_evt(input logic [7:0] code, input logic ext, input logic prs,
                          output int busy_cycles);
    @(negedge CLK);
    send_evt(code, ext, prs);
    run(40, busy_cycles);
  endtask

  initial begin
    RESET = 1'b1; ps2_key = 11'd0; dn_addr = 16'd0; dn_data = 8'd0;
    dn_wr = 1'b0; dn_index = 8'd0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset_btn", 32'(btn), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Wildcard entry 0: 0x75 -> btn[3]
    wr_entry(0, 8'h75, 8'hC3);
    @(negedge CLK);
    send_evt(8'h75, 1'b1, 1'b1);
    chk("busy_c0", 32'(busy), 32'h0);
    @(negedge CLK);
    chk("btn_c1", 32'(btn), 32'h0);
    chk("busy_c1", 32'(busy), 32'h1);
    @(negedge CLK);
    chk("btn_c2", 32'(btn), 32'h0008);
    run(38, bcnt);
    chk("busy_len_press", 32'(bcnt + 2), 32'd32);
    scan_evt(8'h75, 1'b1, 1'b0, bcnt);
    chk("release_btn3", 32'(btn), 32'h0);
    chk("busy_len_rel", 32'(bcnt), 32'd32);

    // Two non-extended-only entries for 0x29 -> btn[0] and btn[5]
    wr_entry(1, 8'h29, 8'h80);
    wr_entry(2, 8'h29, 8'h85);
    scan_evt(8'h29, 1'b0, 1'b1, bcnt);
    chk("multi_press", 32'(btn), 32'h0021);
    scan_evt(8'h29, 1'b1, 1'b0, bcnt);
    chk("ext_no_match", 32'(btn), 32'h0021);
    scan_evt(8'h29, 1'b0, 1'b0, bcnt);
    chk("multi_release", 32'(btn), 32'h0);

    // Three toggles inside one scan: second is overwritten by the third
    wr_entry(3, 8'h16, 8'hC1);
    wr_entry(4, 8'h1E, 8'hC6);
    @(negedge CLK);
    send_evt(8'h16, 1'b0, 1'b1);
    bcnt = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge CLK);
      bcnt += int'(busy);
      if (i == 3) send_evt(8'h1E, 1'b0, 1'b1);
      if (i == 6) send_evt(8'h16, 1'b0, 1'b0);
      if (i == 10) chk("first_scan_btn", 32'(btn), 32'h0002);
      if (i == 33) chk("back_to_back", 32'(busy), 32'h1);
      if (i == 65) chk("second_scan_end", 32'(busy), 32'h0);
    end
    chk("two_scan_busy", 32'(bcnt), 32'd64);
    chk("latest_wins_btn", 32'(btn), 32'h0);

    // Ignored writes: wrong index, and address 2*NUM_KEYS (would alias entry 0)
    wr_byte(16'd10, 8'h3A, 8'd0);
    wr_byte(16'd11, 8'hC7, 8'd0);
    wr_byte(16'd64, 8'h3A, 8'd253);
    wr_byte(16'd65, 8'hC7, 8'd253);
    scan_evt(8'h3A, 1'b0, 1'b1, bcnt);
    chk("ignored_writes", 32'(btn), 32'h0);
    scan_evt(8'h75, 1'b1, 1'b1, bcnt);
    chk("entry0_intact", 32'(btn), 32'h0008);
    scan_evt(8'h75, 1'b1, 1'b0, bcnt);
    // btn_idx = NUM_BTN must never touch btn
    wr_entry(6, 8'h4D, 8'h90);
    scan_evt(8'h4D, 1'b0, 1'b1, bcnt);
    chk("idx_out_of_range", 32'(btn), 32'h0);

    // Invalidating a held button's entry leaves it held
    wr_entry(7, 8'h5A, 8'hC4);
    scan_evt(8'h5A, 1'b0, 1'b1, bcnt);
    chk("btn4_press", 32'(btn), 32'h0010);
    wr_entry(7, 8'h5A, 8'h44);
    @(negedge CLK);
    chk("invalidate_hold", 32'(btn), 32'h0010);
    scan_evt(8'h5A, 1'b0, 1'b0, bcnt);
    chk("release_after_inval", 32'(btn), 32'h0010);

    // Reset mid-scan with a toggle during reset
    wr_entry(8, 8'h12, 8'hC2);
    scan_evt(8'h12, 1'b0, 1'b1, bcnt);
    chk("btn2_press", 32'(btn), 32'h0014);
    @(negedge CLK);
    send_evt(8'h12, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    send_evt(8'h75, 1'b1, 1'b1);
    @(negedge CLK);
    RESET = 1'b0;
    chk("rst_btn", 32'(btn), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    run(40, bcnt);
    chk("no_spurious_evt", 32'(bcnt), 32'd0);
    scan_evt(8'h75, 1'b1, 1'b1, bcnt);
    chk("table_cleared", 32'(btn), 32'h0);
    chk("scan_after_rst", 32'(bcnt), 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
